axis_skid_buffer: RTL and testbench
===================================

AXIS_SKID_BUFFER -- requirements
Module: axis_skid_buffer

Interface
REQ-001 SHALL have parameter: TDATA_WIDTH, 32, tdata width in bits; it SHALL match both axis_if instances.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: axis_sif  axis_if slave  tvalid/tdata[TDATA_WIDTH-1:0] in, tready out  upstream stream.
REQ-005 SHALL have port: axis_mif  axis_if master  tvalid/tdata out, tready in  downstream stream.
REQ-006 SHALL have port: invalidate  input  1  synchronous flush of all buffered beats.

Function
REQ-007 SHALL be a backward-path (tready-registered) slice: axis_sif.tready, axis_mif.tvalid and axis_mif.tdata SHALL each be driven directly from flops, with no combinational path from any input.
REQ-008 SHALL hold at most two beats: output register OUT, which drives axis_mif.tdata, and skid register SKID.
REQ-009 SHALL implement the states EMPTY (0 beats), BUSY (OUT valid) and FULL (OUT and SKID valid).
REQ-010 SHALL drive axis_mif.tvalid = 1 in BUSY and FULL, and 0 in EMPTY.
REQ-011 SHALL drive axis_sif.tready = 1 in EMPTY and BUSY, and 0 in FULL; the value SHALL be registered alongside the state.
REQ-012 SHALL treat an input handshake as axis_sif.tvalid & axis_sif.tready, and an output handshake as axis_mif.tvalid & axis_mif.tready.
REQ-013 SHALL, in EMPTY: on input handshake, load OUT from axis_sif.tdata and go to BUSY; otherwise stay in EMPTY.
REQ-014 SHALL, in BUSY:
- input only: load SKID and go to FULL;
- output only: go to EMPTY;
- both: load OUT from input and stay in BUSY;
- neither: hold.
REQ-015 SHALL, in FULL: on output handshake, copy SKID to OUT and go to BUSY; otherwise hold OUT and SKID unchanged.
REQ-016 SHALL have a latency of 1 cycle from input handshake to axis_mif.tvalid = 1 when EMPTY.
REQ-017 SHALL sustain 1 beat per cycle while axis_mif.tready stays 1.
REQ-018 SHALL preserve beat order and data bit-exactly; no beat SHALL be lost or duplicated except by invalidate.
REQ-019 SHALL keep axis_mif.tvalid and axis_mif.tdata stable while axis_mif.tvalid = 1 and axis_mif.tready = 0.
REQ-020 SHALL give invalidate priority over all transitions: the next state SHALL be EMPTY and the next axis_sif.tready SHALL be 1.
REQ-021 SHALL, in the invalidate cycle:
- keep registered outputs at their current values;
- complete and discard any output handshake;
- accept and discard any input handshake.
REQ-022 SHALL leave OUT and SKID contents don't-care after invalidate; only tvalid matters.
REQ-023 SHALL stay in EMPTY when invalidate is held for multiple cycles; every accepted input beat SHALL be discarded.

Reset
REQ-024 SHALL, while rst_n = 0, force state EMPTY, axis_mif.tvalid = 0, axis_sif.tready = 0, and OUT = SKID = 0, independent of clk.
REQ-025 SHALL raise axis_sif.tready to 1 on the first rising clk edge after rst_n deasserts.
REQ-026 SHALL, on reset assertion mid-operation (BUSY or FULL), discard all beats immediately and drop axis_mif.tvalid asynchronously.

Verification
REQ-027 SHALL cover pass-through: tready = 1 constantly, inputs 0x1..0x8 back-to-back -> outputs 0x1..0x8 at 1 beat/cycle, 1-cycle latency.
REQ-028 SHALL cover skid: send 0xA, 0xB, 0xC with axis_mif.tready = 0:
- 0xA and 0xB accepted, FULL, axis_sif.tready = 0, 0xC held upstream;
- then tready = 1 -> 0xA, 0xB, 0xC delivered in order.
REQ-029 SHALL cover stall stability: axis_mif.tready toggling randomly -> tdata constant while stalled; scoreboard matches in order.
REQ-030 SHALL cover invalidate in FULL with a simultaneous output handshake:
- next cycle EMPTY, axis_mif.tvalid = 0, axis_sif.tready = 1;
- the next input 0x55 is delivered alone.
REQ-031 SHALL cover reset: reset asserted in FULL -> axis_mif.tvalid = 0 and axis_sif.tready = 0 without a clock edge; after release, tready = 1 after one edge.
REQ-032 SHALL cover the simultaneous in/out handshake in BUSY: OUT = 0x3, input 0x4 -> next cycle tdata = 0x4, state BUSY, axis_sif.tready = 1.

Source files
------------

// File: rtl/axis_skid_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module      : axis_if
//  Description : Minimal AXI4-Stream channel (tvalid / tready / tdata) with
//                master and slave views for point-to-point stream links.
//  Revision    : 1.0 - initial release
// ============================================================================
interface axis_if #(
  parameter int TDATA_WIDTH = 32
);
  logic                   tvalid;
  logic                   tready;
  logic [TDATA_WIDTH-1:0] tdata;

  // Producer side: drives the beat, observes back-pressure.
  modport master (
    output tvalid,
    output tdata,
    input  tready
  );

  // Consumer side: observes the beat, drives back-pressure.
  modport slave (
    input  tvalid,
    input  tdata,
    output tready
  );
endinterface
`default_nettype wire

// File: rtl/axis_skid_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : axis_skid_buffer
//  Description : Two-entry AXI4-Stream register slice that breaks the
//                backward (tready) path. Every output is a flop. OUT holds
//                the beat presented downstream; SKID catches the one beat
//                that may arrive in the cycle tready is still high while
//                downstream stalls. A synchronous invalidate flushes both.
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_skid_buffer #(
  parameter int TDATA_WIDTH = 32
) (
  input  logic    clk,
  input  logic    rst_n,
  axis_if.slave   axis_sif,
  axis_if.master  axis_mif,
  input  logic    invalidate
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,   // no beats held
    BUSY  = 2'd1,   // OUT valid
    FULL  = 2'd2    // OUT and SKID valid
  } state_t;

  state_t                 state_q, state_d;
  logic [TDATA_WIDTH-1:0] out_q,   out_d;
  logic [TDATA_WIDTH-1:0] skid_q,  skid_d;
  logic                   tvalid_q, tvalid_d;
  logic                   tready_q, tready_d;

  logic                   in_hs;
  logic                   out_hs;

  // Handshakes are qualified with the registered flags so no input reaches
  // an output combinationally.
  assign in_hs  = axis_sif.tvalid & tready_q;
  assign out_hs = tvalid_q & axis_mif.tready;

  // Next-state, next-data and next-flag computation.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;

    case (state_q)
      EMPTY: begin
        if (in_hs) begin
          out_d   = axis_sif.tdata;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (in_hs && out_hs) begin
          out_d   = axis_sif.tdata;
        end else if (in_hs) begin
          skid_d  = axis_sif.tdata;
          state_d = FULL;
        end else if (out_hs) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_hs) begin
          out_d   = skid_q;
          state_d = BUSY;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase

    // Flush wins over everything; any beat handshaken this cycle is dropped
    // and the data registers are left as whatever they happened to load.
    if (invalidate) begin
      state_d = EMPTY;
    end

    // Output flags are pure functions of the next state so they land in
    // flops together with it.
    tvalid_d = (state_d != EMPTY);
    tready_d = (state_d != FULL);
  end

  // State, data and flag registers; async reset clears all beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= EMPTY;
      out_q    <= '0;
      skid_q   <= '0;
      tvalid_q <= 1'b0;
      tready_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      skid_q   <= skid_d;
      tvalid_q <= tvalid_d;
      tready_q <= tready_d;
    end
  end

  assign axis_sif.tready = tready_q;
  assign axis_mif.tvalid = tvalid_q;
  assign axis_mif.tdata  = out_q;

endmodule
`default_nettype wire

// File: tb/tb_axis_skid_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axis_skid_buffer
//  Description : Self-checking bench for axis_skid_buffer: directed vector
//                table, reset corner case and a randomized run against a
//                queue-based model of the stream contents.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_skid_buffer;

  localparam int W = 32;

  logic clk;
  logic rst_n;
  logic inv;

  axis_if #(.TDATA_WIDTH(W)) s_if ();
  axis_if #(.TDATA_WIDTH(W)) m_if ();

  axis_skid_buffer #(.TDATA_WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .axis_sif   (s_if),
    .axis_mif   (m_if),
    .invalidate (inv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         v;
    logic [W-1:0] d;
    logic         rdy;
    logic         inv;
    logic         ev;
    logic [W-1:0] ed;
    logic         er;
  } vec_t;

  vec_t         vq[$];
  logic [W-1:0] mq[$];
  int           n_cmp;
  int           n_bad;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic v, input logic [W-1:0] d, input logic rdy, input logic iv,
                     input logic ev, input logic [W-1:0] ed, input logic er);
    vec_t r;
    r.v = v; r.d = d; r.rdy = rdy; r.inv = iv; r.ev = ev; r.ed = ed; r.er = er;
    vq.push_back(r);
  endtask

  task automatic drive(input logic v, input logic [W-1:0] d, input logic rdy, input logic iv);
    s_if.tvalid = v;
    s_if.tdata  = d;
    m_if.tready = rdy;
    inv         = iv;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    drive(1'b0, '0, 1'b0, 1'b0);
    rst_n = 1'b0;

    // Reset state observed with no clock edge yet.
    #2;
    chk("rst_tvalid", {31'd0, m_if.tvalid}, 32'd0);
    chk("rst_tready", {31'd0, s_if.tready}, 32'd0);
    chk("rst_tdata",  m_if.tdata, 32'd0);

    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel_tready", {31'd0, s_if.tready}, 32'd1);
    chk("rel_tvalid", {31'd0, m_if.tvalid}, 32'd0);

    // ---------------- directed table ----------------
    //   v  data    rdy inv | ev  edata   er
    // skid: A, B accepted, C held upstream, then drained in order
    add(1, 32'hA,  0, 0,   1, 32'hA,  1);
    add(1, 32'hB,  0, 0,   1, 32'hA,  0);
    add(1, 32'hC,  0, 0,   1, 32'hA,  0);
    add(1, 32'hC,  1, 0,   1, 32'hB,  1);
    add(1, 32'hC,  1, 0,   1, 32'hC,  1);
    add(0, 32'h0,  1, 0,   0, 32'h0,  1);
    // invalidate in FULL with a simultaneous output handshake
    add(1, 32'h11, 0, 0,   1, 32'h11, 1);
    add(1, 32'h22, 0, 0,   1, 32'h11, 0);
    add(0, 32'h0,  1, 1,   0, 32'h0,  1);
    add(1, 32'h55, 0, 0,   1, 32'h55, 1);
    add(0, 32'h0,  1, 0,   0, 32'h0,  1);
    // simultaneous in/out handshake in BUSY
    add(1, 32'h3,  0, 0,   1, 32'h3,  1);
    add(1, 32'h4,  1, 0,   1, 32'h4,  1);
    add(0, 32'h0,  1, 0,   0, 32'h0,  1);
    // invalidate held over accepted beats
    add(1, 32'h7,  0, 1,   0, 32'h0,  1);
    add(1, 32'h8,  0, 1,   0, 32'h0,  1);
    add(0, 32'h0,  0, 0,   0, 32'h0,  1);
    // pass-through 1..8, one beat per cycle, one-cycle latency
    for (int i = 1; i <= 8; i++) begin
      add(1, W'(i), 1, 0,  1, W'(i),  1);
    end
    add(0, 32'h0,  1, 0,   0, 32'h0,  1);

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].v, vq[i].d, vq[i].rdy, vq[i].inv);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_tvalid", i), {31'd0, m_if.tvalid}, {31'd0, vq[i].ev});
      chk($sformatf("vec%0d_tready", i), {31'd0, s_if.tready}, {31'd0, vq[i].er});
      if (vq[i].ev) chk($sformatf("vec%0d_tdata", i), m_if.tdata, vq[i].ed);
    end

    // ---------------- reset asserted while FULL ----------------
    drive(1, 32'hAA, 0, 0);
    @(posedge clk); #1;
    drive(1, 32'hBB, 0, 0);
    @(posedge clk); #1;
    chk("full_tready", {31'd0, s_if.tready}, 32'd0);
    chk("full_tvalid", {31'd0, m_if.tvalid}, 32'd1);
    chk("full_tdata",  m_if.tdata, 32'hAA);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_tvalid", {31'd0, m_if.tvalid}, 32'd0);
    chk("arst_tready", {31'd0, s_if.tready}, 32'd0);
    drive(0, '0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("arel_tready", {31'd0, s_if.tready}, 32'd1);
    chk("arel_tvalid", {31'd0, m_if.tvalid}, 32'd0);

    // ---------------- randomized run against stream model ----------------
    mq.delete();
    for (int c = 0; c < 400; c++) begin
      logic in_hs;
      logic out_hs;
      drive(1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 24) == 0));
      // Buffer holds at most two beats; head of the queue is what is shown.
      in_hs  = s_if.tvalid && (mq.size() < 2);
      out_hs = (mq.size() > 0) && m_if.tready;
      if (out_hs) void'(mq.pop_front());
      if (inv) mq.delete();
      else if (in_hs) mq.push_back(s_if.tdata);
      @(posedge clk); #1;
      chk("rnd_tvalid", {31'd0, m_if.tvalid}, {31'd0, mq.size() > 0});
      chk("rnd_tready", {31'd0, s_if.tready}, {31'd0, mq.size() < 2});
      if (mq.size() > 0) chk("rnd_tdata", m_if.tdata, mq[0]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
